// File: rtl/mmss_timer_if.sv
// Display/button bundle between the mm:ss timer and its environment.
// The master drives the timebase, buttons and mode; the slave returns the BCD count and status.
interface mmss_timer_if;
  logic        second_toggle;
  logic        btn_start;
  logic        btn_clear;
  logic        count_down;
  logic [15:0] preset_bcd;
  logic [15:0] four_hex_out;
  logic        running;
  logic        expired;

  modport master (
    output second_toggle, btn_start, btn_clear, count_down, preset_bcd,
    input  four_hex_out, running, expired
  );

  modport slave (
    input  second_toggle, btn_start, btn_clear, count_down, preset_bcd,
    output four_hex_out, running, expired
  );
endinterface

// File: rtl/mmss_timer.sv
// Minutes:seconds stopwatch / countdown timer producing a {M10,M1,S10,S1} BCD word.
// Timebase is the display driver's once-per-second toggle; two raw buttons are debounced here.
module mmss_timer #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TOGGLE_SYNC     = 1
) (
  input  logic         clk,
  input  logic         rst,
  mmss_timer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Digit i of the packed word: 0 = S1, 1 = S10, 2 = M1, 3 = M10.
  function automatic logic [3:0] digit_max(input int i);
    return ((i % 2) != 0) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [3:0][3:0] d;
    logic            carry;
    d     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i] == digit_max(i)) d[i] = 4'd0;
        else begin
          d[i]  = d[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return d;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0][3:0] d;
    logic            borrow;
    d      = v;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (d[i] == 4'd0) d[i] = digit_max(i);
        else begin
          d[i]   = d[i] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return d;
  endfunction

  function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
    logic [3:0][3:0] d;
    d = v;
    for (int i = 0; i < 4; i++)
      if (d[i] > digit_max(i)) d[i] = digit_max(i);
    return d;
  endfunction

  // ---------------- second timebase ----------------
  logic tog_sync;
  logic tog_hist_q;
  logic sec_tick;

  generate
    if (TOGGLE_SYNC != 0) begin : g_tog_sync
      logic tog_s1_q, tog_s2_q;
      // NOTE: synchronizer flops carry no reset; they only track the input and
      // resetting them would fake an edge when second_toggle is high.
      always_ff @(posedge clk) begin
        tog_s1_q <= bus.second_toggle;
        tog_s2_q <= tog_s1_q;
      end
      assign tog_sync = tog_s2_q;
    end else begin : g_tog_direct
      assign tog_sync = bus.second_toggle;
    end
  endgenerate

  // History follows the synchronized level in and out of reset, so reset never yields a tick.
  always_ff @(posedge clk) tog_hist_q <= tog_sync;

  assign sec_tick = tog_sync ^ tog_hist_q;

  // ---------------- button debounce ----------------
  logic [1:0]    btn_raw;
  logic [1:0]    bs1_q, bs2_q, stable_q, press_q;
  logic [CW-1:0] cnt_q [2];
  logic          start_p, clear_p;

  assign btn_raw = {bus.btn_clear, bus.btn_start};

  always_ff @(posedge clk) begin
    if (rst) begin
      bs1_q    <= '0;
      bs2_q    <= '0;
      stable_q <= '0;
      press_q  <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      bs1_q <= btn_raw;
      bs2_q <= bs1_q;
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (bs2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_q[i] <= bs2_q[i];
          press_q[i]  <= bs2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign start_p = press_q[0];
  assign clear_p = press_q[1];

  // ---------------- count datapath ----------------
  state_e      state_q;
  logic [15:0] count_q;
  logic        mode_dn_q;
  logic        running_q, expired_q;
  logic [15:0] step_d, load_d;
  logic        step_done;

  always_comb begin
    step_d    = count_q;
    step_done = 1'b0;
    if (mode_dn_q) begin
      if (count_q == 16'h0000) begin
        step_done = 1'b1;
      end else begin
        step_d    = bcd_dec(count_q);
        step_done = (step_d == 16'h0000);
      end
    end else if (count_q == 16'h5959) begin
      step_done = 1'b1;
    end else begin
      step_d = bcd_inc(count_q);
    end
  end

  assign load_d = bus.count_down ? bcd_clamp(bus.preset_bcd) : 16'h0000;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 16'h0000;
      mode_dn_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clear_p) begin
            count_q <= load_d;
          end else if (start_p) begin
            if (bus.count_down && count_q == 16'h0000) begin
              state_q   <= DONE;
              expired_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              running_q <= 1'b1;
              mode_dn_q <= bus.count_down;
            end
          end
        end
        RUN: begin
          if (clear_p) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            count_q   <= load_d;
          end else begin
            if (sec_tick) count_q <= step_d;
            // Reaching the terminal count outranks a simultaneous pause request.
            if (sec_tick && step_done) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              expired_q <= 1'b1;
            end else if (start_p) begin
              state_q   <= PAUSE;
              running_q <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (clear_p) begin
            state_q <= IDLE;
            count_q <= load_d;
          end else if (start_p) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end
        DONE: begin
          if (clear_p) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
            count_q   <= load_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.four_hex_out = count_q;
  assign bus.running      = running_q;
  assign bus.expired      = expired_q;

endmodule
